multiport_data_mem: RTL

//  Shared data memory for the N-core processor top; generalises the two-port data RAM to PORT_COUNT ports.

---
 rtl/mem_pkg.sv | 17 +
 rtl/rr_write_arbiter.sv | 59 +++++
 rtl/multiport_data_mem.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the multiport data memory.
package mem_pkg;

    localparam int CONFLICT_CNT_W = 16;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Index width for a set of n items. It is at least one bit, so a
    // single-port or single-word build still has a usable vector.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_write_arbiter.sv
// Round-robin arbiter that settles same-address write collisions between ports.
module rr_write_arbiter
    import mem_pkg::*;
#(
    parameter int PORT_COUNT = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int PORT_IDX_W = idx_w(PORT_COUNT)
) (
    input  logic [PORT_COUNT-1:0]            req,
    input  logic [PORT_COUNT-1:0]            we,
    input  logic [PORT_COUNT*ADDR_WIDTH-1:0] addr,
    input  logic [PORT_IDX_W-1:0]            rr_ptr,
    output logic [PORT_COUNT-1:0]            write_grant,
    output logic                             collision,
    output logic [PORT_IDX_W-1:0]            next_ptr
);

    logic [PORT_COUNT-1:0] wr;
    logic [PORT_COUNT-1:0] collide;
    logic                  found;

    assign wr = req & we;

    // Priority distance from the pointer: 0 is the port rr_ptr points at.
    function automatic int rank(input int i, input int ptr);
        return (i >= ptr) ? i - ptr : i + PORT_COUNT - ptr;
    endfunction

    // A writer wins unless another writer to the same address sits closer to rr_ptr.
    // The pointer moves past the lowest-index winner of any colliding group.
    always_comb begin
        write_grant = '0;
        collide     = '0;
        collision   = 1'b0;
        next_ptr    = rr_ptr;
        found       = 1'b0;
        for (int p = 0; p < PORT_COUNT; p++) begin
            if (wr[p]) begin
                write_grant[p] = 1'b1;
                for (int q = 0; q < PORT_COUNT; q++) begin
                    if (q != p && wr[q] &&
                        addr[q*ADDR_WIDTH +: ADDR_WIDTH] == addr[p*ADDR_WIDTH +: ADDR_WIDTH]) begin
                        collide[p] = 1'b1;
                        if (rank(q, int'(rr_ptr)) < rank(p, int'(rr_ptr)))
                            write_grant[p] = 1'b0;
                    end
                end
            end
        end
        for (int p = 0; p < PORT_COUNT; p++) begin
            if (collide[p]) collision = 1'b1;
            if (collide[p] && write_grant[p] && !found) begin
                found    = 1'b1;
                next_ptr = PORT_IDX_W'((p + 1) % PORT_COUNT);
            end
        end
    end

endmodule

// File: rtl/multiport_data_mem.sv
// Shared multiport data memory: zero-fill after reset, per-port reads,
// arbitrated same-address writes, registered read data.
module multiport_data_mem
    import mem_pkg::*;
#(
    parameter int MEM_SIZE   = 4096,
    parameter int MEM_WIDTH  = 12,
    parameter int ADDR_WIDTH = 12,
    parameter int PORT_COUNT = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [PORT_COUNT-1:0]           req,
    input  logic [PORT_COUNT-1:0]           we,
    input  logic [PORT_COUNT*ADDR_WIDTH-1:0] addr,
    input  logic [PORT_COUNT*MEM_WIDTH-1:0] wdata,
    output logic [PORT_COUNT-1:0]           grant,
    output logic [PORT_COUNT*MEM_WIDTH-1:0] rdata,
    output logic [PORT_COUNT-1:0]           rvalid,
    output logic [PORT_COUNT-1:0]           addr_err,
    output logic                            busy,
    output logic [CONFLICT_CNT_W-1:0]       conflicts
);

    localparam int          PORT_IDX_W = idx_w(PORT_COUNT);
    localparam int          MEM_IDX_W  = idx_w(MEM_SIZE);
    localparam logic [31:0] MEM_LIMIT  = MEM_SIZE;

    state_t                 state, state_nxt;
    logic [MEM_IDX_W-1:0]   clr_addr;
    logic [PORT_IDX_W-1:0]  rr_ptr, next_ptr;
    logic [PORT_COUNT-1:0]  write_grant;
    logic                   collision;
    logic [PORT_COUNT-1:0]  in_range;
    logic [MEM_WIDTH-1:0]   mem [MEM_SIZE];

    rr_write_arbiter #(
        .PORT_COUNT (PORT_COUNT),
        .ADDR_WIDTH (ADDR_WIDTH),
        .PORT_IDX_W (PORT_IDX_W)
    ) u_arb (
        .req         (req),
        .we          (we),
        .addr        (addr),
        .rr_ptr      (rr_ptr),
        .write_grant (write_grant),
        .collision   (collision),
        .next_ptr    (next_ptr)
    );

    // Per-port range check; out-of-range accesses are granted but never touch the array.
    always_comb begin
        in_range = '0;
        for (int p = 0; p < PORT_COUNT; p++)
            in_range[p] = 32'(addr[p*ADDR_WIDTH +: ADDR_WIDTH]) < MEM_LIMIT;
    end

    assign busy  = (state == CLEAR);
    assign grant = (state == RUN) ? ((req & ~we) | write_grant) : '0;

    // State register and clear-address counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
        end
    end

    // Leave CLEAR once the last word has been zeroed; RUN is held until reset.
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_addr == MEM_IDX_W'(MEM_SIZE - 1)) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Array write port: zero-fill during CLEAR, granted in-range writes during RUN.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_addr] <= '0;
        end else begin
            for (int p = 0; p < PORT_COUNT; p++)
                if (grant[p] && we[p] && in_range[p])
                    mem[MEM_IDX_W'(addr[p*ADDR_WIDTH +: ADDR_WIDTH])] <= wdata[p*MEM_WIDTH +: MEM_WIDTH];
        end
    end

    // Registered reads; sampling mem with non-blocking semantics gives read-before-write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata    <= '0;
            rvalid   <= '0;
            addr_err <= '0;
        end else begin
            for (int p = 0; p < PORT_COUNT; p++) begin
                rvalid[p]   <= grant[p] & ~we[p];
                addr_err[p] <= grant[p] & ~in_range[p];
                if (grant[p] && !we[p])
                    rdata[p*MEM_WIDTH +: MEM_WIDTH] <= in_range[p]
                        ? mem[MEM_IDX_W'(addr[p*ADDR_WIDTH +: ADDR_WIDTH])] : '0;
            end
        end
    end

    // Rotate priority and count collision cycles (saturating).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr    <= '0;
            conflicts <= '0;
        end else if (state == RUN && collision) begin
            rr_ptr <= next_ptr;
            if (conflicts != '1) conflicts <= conflicts + 1'b1;
        end
    end

endmodule
